stim_channel_scheduler: RTL and testbench
=========================================

Name: stim_channel_scheduler

Overview:
Time-multiplexes the shared 4-bit electrode switch select between the stimulation channels. Drives the select input of the address multiplexer, plus a switch-enable.
- Round-robin over the enabled channels.
- Programmable dwell per slot.
- Fixed break-before-make gap, so the switch matrix is never enabled while the select code changes.
- Sits between the control registers and the address multiplexer / switch driver.

Parameters:
N_CH, 2, number of channels, 1..16; the select code is 4 bits.
DWELL_W, 16, width of the dwell-length input.
GAP_CYC, 4, break-before-make cycles with sw_en low; minimum 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; run while high
ch_mask  in  N_CH  channel enable mask; bit i enables channel i
dwell_len  in  DWELL_W  enabled cycles per slot; 0 is treated as 1
select  out  4  channel code to the address multiplexer select
sw_en  out  1  switch matrix enable
ch_switch  out  1  1-cycle pulse on the first cycle of each dwell
round_done  out  1  1-cycle pulse when selection wraps to the lowest enabled channel
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, select=0, sw_en=0, ch_switch=0, round_done=0, busy=0, all counters 0.
- States: IDLE, GAP, DWELL.
- IDLE:
  - Exits when start=1 and ch_mask!=0 are sampled at a clock edge. Next cycle is GAP.
  - start=1 with ch_mask=0: remain IDLE.
- GAP:
  - sw_en=0 throughout; lasts exactly GAP_CYC cycles.
  - Gap cycle 0 keeps the old select.
  - At the end of gap cycle 0, select loads the next channel, and ch_mask/dwell_len are latched into shadow registers.
  - This guarantees at least 1 cycle of sw_en=0 before, and GAP_CYC-1 cycles after, any select change.
  - After GAP_CYC cycles: go to DWELL.
- DWELL:
  - sw_en=1 for max(dwell_len_shadow,1) cycles.
  - ch_switch=1 on the first dwell cycle.
  - At the end of the dwell: if start=1 and ch_mask!=0, go to GAP; otherwise go to IDLE.
  - sw_en goes to 0 on the first cycle after the last dwell cycle.
- Next-channel rule, evaluated on the live ch_mask at gap cycle 0:
  - Lowest set bit with index greater than the current channel; otherwise wrap to the lowest set bit.
  - First slot after IDLE: lowest set bit.
  - Single enabled channel: same code is reselected and the gap is still applied.
  - Mask zero at gap cycle 0: abort to IDLE; select holds.
- round_done:
  - Pulses on the first dwell cycle of a slot whose channel index ≤ the previous slot's index.
  - Does not pulse on the first slot after IDLE.
- start low mid-slot: the current dwell completes, then IDLE. A GAP in progress completes its dwell before stopping.
- ch_mask/dwell_len changes: take effect only at the next gap cycle 0; no glitch on a running dwell.
- Counter widths: dwell counter is DWELL_W bits, gap counter is clog2(GAP_CYC) bits. No wrap occurs because counters reset per slot.
- Reset asserted mid-operation: all outputs take reset values immediately (async); sw_en drops without waiting for a gap.
- Latency:
  - start sampled at edge k → busy=1, state GAP from cycle k+1.
  - sw_en=1 from cycle k+1+GAP_CYC.

Optional Feature:
Macro STIM_SCHED_ROUND_CNT_EN.
- Defined: adds output round_cnt[15:0], which increments on each round_done pulse.
  - Wraps 0xFFFF→0.
  - Cleared by reset and on each IDLE→GAP transition.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package stim_sched_pkg holds:
  - state enum {IDLE, GAP, DWELL}
  - SEL_W=4
  - GAP_MIN=2
  - function clog2 for counter sizing
- Sub-module stim_next_ch is natural: combinational round-robin finder.
  - Inputs: mask, current index, first flag.
  - Outputs: next index, wrap flag, none-set flag.

Test Plan:
- N_CH=2, GAP_CYC=4, dwell_len=10, mask=2'b11, start held:
  - sw_en pattern repeats: 4 low, 10 high.
  - select alternates 0,1,0,…, changing only while sw_en=0.
  - round_done pulses on each channel-0 dwell start except the first.
- mask=2'b10:
  - select=1 on every slot, gap still present between dwells.
  - round_done pulses every slot from the second onward.
- start dropped 3 cycles into a dwell:
  - The dwell finishes all 10 cycles, then busy=0 and sw_en=0; no further gap.
- dwell_len changed from 10 to 3 mid-dwell:
  - Current dwell stays 10; next dwell is 3.
  - dwell_len=0 gives a 1-cycle dwell.
- rst_n pulsed low mid-dwell:
  - sw_en, busy, and select go to 0 asynchronously.
  - After release with start=1, the first slot is the lowest enabled channel.
- With STIM_SCHED_ROUND_CNT_EN, mask=2'b11, 5 full rounds: round_cnt=4; after restart from IDLE, round_cnt=0.

Source files
------------

// File: rtl/stim_sched_pkg.sv
// Shared types and sizing helpers for the stimulation channel scheduler.
package stim_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        DWELL = 2'd2
    } state_t;

    localparam int SEL_W   = 4;
    localparam int GAP_MIN = 2;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stim_next_ch.sv
// Combinational round-robin finder: picks the lowest enabled channel above the
// current one, otherwise wraps to the lowest enabled channel.
module stim_next_ch
    import stim_sched_pkg::*;
#(
    parameter int N_CH = 2
)(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur_idx,
    input  logic             first,
    output logic [SEL_W-1:0] next_idx,
    output logic             wrap,
    output logic             none_set
);

    logic [SEL_W-1:0] lowest_idx;
    logic [SEL_W-1:0] above_idx;
    logic             found_low;
    logic             found_above;

    // Scan from the top down so the last hit is the lowest qualifying bit.
    always_comb begin
        lowest_idx  = '0;
        above_idx   = '0;
        found_low   = 1'b0;
        found_above = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_idx = SEL_W'(i);
                found_low  = 1'b1;
                if (SEL_W'(i) > cur_idx) begin
                    above_idx   = SEL_W'(i);
                    found_above = 1'b1;
                end
            end
        end
        none_set = !found_low;
        wrap     = !first && !found_above;
        next_idx = (first || !found_above) ? lowest_idx : above_idx;
    end

endmodule

// File: rtl/stim_channel_scheduler.sv
// Round-robin scheduler for the shared electrode switch select, with a fixed
// break-before-make gap around every select change.
// Optional macro STIM_SCHED_ROUND_CNT_EN adds the round_cnt output.
module stim_channel_scheduler
    import stim_sched_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DWELL_W = 16,
    parameter int GAP_CYC = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic [DWELL_W-1:0] dwell_len,
    output logic [SEL_W-1:0]   select,
    output logic               sw_en,
    output logic               ch_switch,
    output logic               round_done,
    output logic               busy
`ifdef STIM_SCHED_ROUND_CNT_EN
    ,
    output logic [15:0]        round_cnt
`endif
);

    // A gap shorter than two cycles could not isolate both sides of a select change.
    localparam int GAP_EFF = (GAP_CYC < GAP_MIN) ? GAP_MIN : GAP_CYC;
    localparam int GAP_W   = clog2(GAP_EFF);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

    state_t             state;
    state_t             state_next;
    logic [GAP_W-1:0]   gap_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_shadow;
    logic               first_slot;
    logic               wrap_q;

    logic [SEL_W-1:0]   next_idx;
    logic               next_wrap;
    logic               next_none;

    logic               run_req;
    logic               gap_first;
    logic               gap_last;
    logic               dwell_last;

    stim_next_ch #(.N_CH(N_CH)) u_next_ch (
        .mask     (ch_mask),
        .cur_idx  (select),
        .first    (first_slot),
        .next_idx (next_idx),
        .wrap     (next_wrap),
        .none_set (next_none)
    );

    assign run_req    = start && (ch_mask != '0);
    assign gap_first  = (state == GAP) && (gap_cnt == '0);
    assign gap_last   = (state == GAP) && (gap_cnt == GAP_LAST);
    assign dwell_last = (state == DWELL) &&
                        ((dwell_shadow == '0) || (dwell_cnt == dwell_shadow - DWELL_W'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        state_next = state;
        sw_en      = 1'b0;
        busy       = 1'b1;
        ch_switch  = 1'b0;
        round_done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (run_req) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_first && next_none) begin
                    state_next = IDLE;
                end else if (gap_last) begin
                    state_next = DWELL;
                end
            end
            DWELL: begin
                sw_en      = 1'b1;
                ch_switch  = (dwell_cnt == '0);
                round_done = (dwell_cnt == '0) && wrap_q;
                if (dwell_last) begin
                    state_next = run_req ? GAP : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Slot bookkeeping: select and dwell length only move at the end of gap cycle 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select       <= '0;
            gap_cnt      <= '0;
            dwell_cnt    <= '0;
            dwell_shadow <= '0;
            first_slot   <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    gap_cnt    <= '0;
                    dwell_cnt  <= '0;
                    first_slot <= 1'b1;
                end
                GAP: begin
                    dwell_cnt <= '0;
                    if (gap_first && next_none) begin
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_last ? '0 : gap_cnt + GAP_W'(1);
                    end
                    if (gap_first && !next_none) begin
                        select       <= next_idx;
                        dwell_shadow <= dwell_len;
                        wrap_q       <= next_wrap;
                        first_slot   <= 1'b0;
                    end
                end
                DWELL: begin
                    gap_cnt   <= '0;
                    dwell_cnt <= dwell_last ? '0 : dwell_cnt + DWELL_W'(1);
                end
                default: begin
                    gap_cnt   <= '0;
                    dwell_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STIM_SCHED_ROUND_CNT_EN
    // Count completed rounds; a fresh run from IDLE starts the count over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_cnt <= '0;
        end else if ((state == IDLE) && run_req) begin
            round_cnt <= '0;
        end else if (round_done) begin
            round_cnt <= round_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stim_channel_scheduler.sv
// Self-checking bench for stim_channel_scheduler (N_CH=2, GAP_CYC=4).
// Expected slots are queued as stimulus is set up and popped as each dwell starts.
module tb_stim_channel_scheduler;

    localparam int GAP_CYC = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [1:0]  ch_mask   = '0;
    logic [15:0] dwell_len = '0;
    logic [3:0]  select;
    logic        sw_en;
    logic        ch_switch;
    logic        round_done;
    logic        busy;
`ifdef STIM_SCHED_ROUND_CNT_EN
    logic [15:0] round_cnt;
`endif

    typedef struct {
        logic [3:0] sel;
        int         len;
        logic       rd;
    } slot_t;

    slot_t      exp_q[$];
    int         checks    = 0;
    int         failures  = 0;
    logic [3:0] prev_sel  = '0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    stim_channel_scheduler #(
        .N_CH    (2),
        .DWELL_W (16),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ch_mask    (ch_mask),
        .dwell_len  (dwell_len),
        .select     (select),
        .sw_en      (sw_en),
        .ch_switch  (ch_switch),
        .round_done (round_done),
        .busy       (busy)
`ifdef STIM_SCHED_ROUND_CNT_EN
        ,
        .round_cnt  (round_cnt)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic push_slot(input logic [3:0] sel, input int len, input logic rd);
        slot_t s;
        s.sel = sel;
        s.len = len;
        s.rd  = rd;
        exp_q.push_back(s);
    endtask

    task automatic apply_stimulus(input logic [1:0] mask, input logic [15:0] dwell, input logic run);
        ch_mask   = mask;
        dwell_len = dwell;
        start     = run;
    endtask

    // Starts on the negedge of gap cycle 0, ends on the negedge after the last dwell cycle.
    task automatic observe_slot(input int chg_cycle, input logic [1:0] new_mask,
                                input logic [15:0] new_dwell, input logic new_start);
        slot_t      exp;
        int         gap_n;
        int         dw_n;
        int         guard;
        logic [3:0] last_gap_sel;
        if (exp_q.size() == 0) begin
            check_output("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        exp = exp_q.pop_front();
        check_output("gap0_select_hold", select, prev_sel);
        gap_n        = 0;
        guard        = 0;
        last_gap_sel = select;
        while (!sw_en && busy && guard < 200) begin
            last_gap_sel = select;
            gap_n++;
            guard++;
            @(negedge clk);
        end
        check_output("gap_length", gap_n, GAP_CYC);
        check_output("select_settled_in_gap", last_gap_sel, exp.sel);
        check_output("dwell_start_switch", ch_switch, 1'b1);
        check_output("dwell_start_round_done", round_done, exp.rd);
        dw_n  = 0;
        guard = 0;
        while (sw_en && guard < 200) begin
            check_output("dwell_select", select, exp.sel);
            if (dw_n > 0) begin
                check_output("dwell_switch_single", ch_switch, 1'b0);
            end
            if (dw_n == chg_cycle) begin
                apply_stimulus(new_mask, new_dwell, new_start);
            end
            dw_n++;
            guard++;
            @(negedge clk);
        end
        check_output("dwell_length", dw_n, exp.len);
        prev_sel = exp.sel;
    endtask

    // Hard stop in case the sequence wedges somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        int guard;

        @(negedge clk);
        @(negedge clk);
        check_output("reset_select", select, 4'd0);
        check_output("reset_sw_en", sw_en, 1'b0);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_ch_switch", ch_switch, 1'b0);
        check_output("reset_round_done", round_done, 1'b0);

        apply_stimulus(2'b11, 16'd10, 1'b1);
        @(negedge clk);
        check_output("held_in_reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        push_slot(4'd0, 10, 1'b0);
        push_slot(4'd1, 10, 1'b0);
        push_slot(4'd0, 10, 1'b1);
        push_slot(4'd1, 10, 1'b0);
        @(negedge clk);
        check_output("latency_busy", busy, 1'b1);
        check_output("latency_sw_en_low", sw_en, 1'b0);
        observe_slot(-1, 2'b11, 16'd10, 1'b1);
        observe_slot(-1, 2'b11, 16'd10, 1'b1);
        observe_slot(-1, 2'b11, 16'd10, 1'b1);
        push_slot(4'd1, 10, 1'b1);
        observe_slot(3, 2'b10, 16'd10, 1'b1);
        push_slot(4'd1, 3, 1'b1);
        observe_slot(3, 2'b10, 16'd3, 1'b1);
        push_slot(4'd1, 1, 1'b1);
        observe_slot(0, 2'b10, 16'd0, 1'b1);
        push_slot(4'd0, 10, 1'b1);
        observe_slot(0, 2'b11, 16'd10, 1'b1);
        observe_slot(3, 2'b11, 16'd10, 1'b0);
        check_output("stop_busy", busy, 1'b0);
        check_output("stop_sw_en", sw_en, 1'b0);
        repeat (6) @(negedge clk);
        check_output("stop_stays_idle", busy, 1'b0);
        check_output("stop_no_gap_select", select, 4'd0);

        apply_stimulus(2'b00, 16'd4, 1'b1);
        repeat (3) @(negedge clk);
        check_output("zero_mask_idle", busy, 1'b0);

        apply_stimulus(2'b11, 16'd4, 1'b1);
        push_slot(4'd0, 4, 1'b0);
        @(negedge clk);
        observe_slot(-1, 2'b11, 16'd4, 1'b1);
        guard = 0;
        while (!sw_en && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        check_output("pre_reset_sw_en", sw_en, 1'b1);
        check_output("pre_reset_select", select, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_sw_en", sw_en, 1'b0);
        check_output("async_reset_busy", busy, 1'b0);
        check_output("async_reset_select", select, 4'd0);
        check_output("async_reset_ch_switch", ch_switch, 1'b0);
        @(negedge clk);
        apply_stimulus(2'b10, 16'd3, 1'b1);
        rst_n    = 1'b1;
        prev_sel = 4'd0;
        push_slot(4'd1, 3, 1'b0);
        push_slot(4'd1, 3, 1'b1);
        @(negedge clk);
        observe_slot(-1, 2'b10, 16'd3, 1'b1);
        observe_slot(0, 2'b10, 16'd3, 1'b0);
        check_output("single_ch_stop_busy", busy, 1'b0);

`ifdef STIM_SCHED_ROUND_CNT_EN
        apply_stimulus(2'b11, 16'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            push_slot(4'(i % 2), 1, (i >= 2) && (i % 2 == 0));
        end
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            observe_slot(-1, 2'b11, 16'd1, 1'b1);
        end
        observe_slot(0, 2'b11, 16'd1, 1'b0);
        check_output("round_cnt_five_rounds", round_cnt, 16'd4);
        apply_stimulus(2'b11, 16'd1, 1'b1);
        push_slot(4'd0, 1, 1'b0);
        @(negedge clk);
        check_output("round_cnt_restart_clear", round_cnt, 16'd0);
        observe_slot(0, 2'b11, 16'd1, 1'b0);
`endif

        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
